frac_baud_gen: RTL and testbench

Parametrised UART baud-rate generator, successor to `baud_gen`. It divides the system clock by an integer-plus-fractional divisor to produce a 1-cycle oversampling tick, and a baud strobe every OVS ticks. Divisor updates are double-buffered and applied only at period boundaries, so the tick never glitches. It sits between the divisor-latch registers (DLL/DLH plus fraction register) and the UART TX/RX engines.

---
 rtl/uart_pkg.sv | 19 +
 rtl/baud_frac_acc.sv | 32 +++
 rtl/frac_baud_gen.sv | 105 ++++++++++
 tb/tb_frac_baud_gen.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: default divisor geometry and the divisor-latch register layout.
// The divisor-latch register block uses the same layout.
package uart_pkg;

   localparam int unsigned DIV_W_DEF  = 16;
   localparam int unsigned FRAC_W_DEF = 4;
   localparam int unsigned OVS_DEF    = 16;

   typedef struct packed {
      logic [DIV_W_DEF-1:0]  div_int;
      logic [FRAC_W_DEF-1:0] div_frac;
   } div_reg_t;

   // Oversample counter width; a single-tick baud period still needs one bit.
   function automatic int unsigned ocnt_width(input int unsigned ovs);
      return (ovs > 1) ? $clog2(ovs) : 1;
   endfunction

endpackage

// File: rtl/baud_frac_acc.sv
// Fractional-divisor accumulator: adds the fraction once per period and reports the
// carry that stretches the next period by one clock.
module baud_frac_acc
   import uart_pkg::*;
#(
   parameter int unsigned FRAC_W = FRAC_W_DEF
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_en,
   input  logic              i_clr,
   input  logic [FRAC_W-1:0] i_frac,
   output logic              o_carry
);

   logic [FRAC_W-1:0] r_acc;
   logic [FRAC_W:0]   w_sum;

   always_comb begin
      w_sum   = {1'b0, r_acc} + {1'b0, i_frac};
      o_carry = w_sum[FRAC_W];
   end

   always_ff @(posedge i_clk) begin
      if (i_rst || i_clr) begin
         r_acc <= '0;
      end else if (i_en) begin
         r_acc <= w_sum[FRAC_W-1:0];
      end
   end

endmodule

// File: rtl/frac_baud_gen.sv
// Fractional UART baud-rate generator: oversample tick every act_int(+carry) clocks and a
// baud strobe every OVS ticks, with double-buffered divisor updates applied at period ends.
module frac_baud_gen
   import uart_pkg::*;
#(
   parameter int unsigned DIV_W  = DIV_W_DEF,
   parameter int unsigned FRAC_W = FRAC_W_DEF,
   parameter int unsigned OVS    = OVS_DEF
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_en,
   input  logic [DIV_W-1:0]  i_div,
   input  logic [FRAC_W-1:0] i_div_frac,
   input  logic              i_div_load,
   output logic              o_tick,
   output logic              o_br,
   output logic              o_upd_pend
);

   localparam int unsigned       OCNT_W    = ocnt_width(OVS);
   localparam logic [OCNT_W-1:0] OCNT_LAST = OCNT_W'(OVS - 1);

   logic [DIV_W-1:0]  r_act_int, r_sh_int, r_cnt;
   logic [FRAC_W-1:0] r_act_frac, r_sh_frac;
   logic [OCNT_W-1:0] r_ocnt;
   logic              r_pend, r_tick, r_br;

   logic              w_halted, w_reload, w_apply, w_carry;
   logic [DIV_W-1:0]  w_src_int, w_act_int_nx, w_cnt_nx;
   logic [FRAC_W-1:0] w_src_frac, w_act_frac_nx;
   logic [OCNT_W-1:0] w_ocnt_nx;

   always_comb begin
      w_halted      = (r_act_int == '0) || !i_en;
      w_reload      = !w_halted && (r_cnt == '0);
      // A load in the applying cycle bypasses the shadow so the last load always wins.
      w_src_int     = i_div_load ? i_div : r_sh_int;
      w_src_frac    = i_div_load ? i_div_frac : r_sh_frac;
      w_apply       = (i_div_load || r_pend) && (w_halted || w_reload);
      w_act_int_nx  = w_apply ? w_src_int : r_act_int;
      w_act_frac_nx = w_apply ? w_src_frac : r_act_frac;

      w_cnt_nx = r_cnt - DIV_W'(1);
      if (w_halted) begin
         w_cnt_nx = w_act_int_nx - DIV_W'(1);
      end else if (w_reload) begin
         w_cnt_nx = w_apply ? (w_src_int - DIV_W'(1))
                            : (r_act_int - DIV_W'(1) + DIV_W'(w_carry));
      end

      w_ocnt_nx = r_ocnt;
      if (w_halted) begin
         w_ocnt_nx = '0;
      end else if (w_reload) begin
         w_ocnt_nx = (r_ocnt == OCNT_LAST) ? '0 : r_ocnt + OCNT_W'(1);
      end
   end

   baud_frac_acc #(
      .FRAC_W (FRAC_W)
   ) u_acc (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_en    (w_reload),
      .i_clr   (w_halted || w_apply),
      .i_frac  (r_act_frac),
      .o_carry (w_carry)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_act_int  <= '0;
         r_act_frac <= '0;
         r_sh_int   <= '0;
         r_sh_frac  <= '0;
         r_pend     <= 1'b0;
         r_cnt      <= '0;
         r_ocnt     <= '0;
         r_tick     <= 1'b0;
         r_br       <= 1'b0;
      end else begin
         r_act_int  <= w_act_int_nx;
         r_act_frac <= w_act_frac_nx;
         if (i_div_load) begin
            r_sh_int  <= i_div;
            r_sh_frac <= i_div_frac;
         end
         if (w_apply) begin
            r_pend <= 1'b0;
         end else if (i_div_load) begin
            r_pend <= 1'b1;
         end
         r_cnt  <= w_cnt_nx;
         r_ocnt <= w_ocnt_nx;
         r_tick <= w_reload;
         r_br   <= w_reload && (r_ocnt == OCNT_LAST);
      end
   end

   assign o_tick     = r_tick;
   assign o_br       = r_br;
   assign o_upd_pend = r_pend;

endmodule

// File: tb/tb_frac_baud_gen.sv
// Directed bench for frac_baud_gen: tick spacing, fractional carries, deferred updates,
// halting, reset, and an OVS=1 instance whose baud strobe must track its tick.
module tb_frac_baud_gen;

   logic        clk = 1'b0;
   logic        rst, en, div_load;
   logic [15:0] div;
   logic [3:0]  div_frac;
   logic        tick, br, upd_pend;
   logic        tick1, br1, upd_pend1;

   int n_chk  = 0;
   int n_pass = 0;
   int stray_br = 0;
   int mis1     = 0;

   always #5 clk = ~clk;

   frac_baud_gen #(.DIV_W(16), .FRAC_W(4), .OVS(16)) dut (
      .i_clk(clk), .i_rst(rst), .i_en(en), .i_div(div), .i_div_frac(div_frac),
      .i_div_load(div_load), .o_tick(tick), .o_br(br), .o_upd_pend(upd_pend)
   );

   frac_baud_gen #(.DIV_W(16), .FRAC_W(4), .OVS(1)) dut1 (
      .i_clk(clk), .i_rst(rst), .i_en(en), .i_div(div), .i_div_frac(div_frac),
      .i_div_load(div_load), .o_tick(tick1), .o_br(br1), .o_upd_pend(upd_pend1)
   );

   task automatic check_eq(input string tag, input int got, input int exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
   endtask

   // Advance one clock; outputs are stable 1 time unit after the edge.
   task automatic step();
      @(posedge clk);
      #1;
      if (br && !tick) stray_br++;
      if (br1 !== tick1 || upd_pend1 !== upd_pend) mis1++;
   endtask

   // Cycles until the next tick, or -1 if none within max_cyc.
   task automatic wait_tick(input int max_cyc, output int gap);
      int n;
      bit got;
      n   = 0;
      got = 1'b0;
      gap = -1;
      while (!got && n < max_cyc) begin
         step();
         n++;
         if (tick) begin
            got = 1'b1;
            gap = n;
         end
      end
   endtask

   // Halt, load a divisor, then re-enable so the next edge is edge 1.
   task automatic restart(input int d, input int f);
      en       = 1'b0;
      div      = 16'(d);
      div_frac = 4'(f);
      div_load = 1'b1;
      step();
      div_load = 1'b0;
      en       = 1'b1;
   endtask

   initial begin
      int g, sum, cnt_t, cnt_b, cnt_b1;
      rst = 1'b1; en = 1'b0; div_load = 1'b0; div = '0; div_frac = '0;
      step();
      step();
      check_eq("rst_tick", int'(tick), 0);
      check_eq("rst_br", int'(br), 0);
      check_eq("rst_pend", int'(upd_pend), 0);

      // div=6 frac=0: ticks every 6, baud strobe on 16th tick
      rst = 1'b0; en = 1'b1; div = 16'd6; div_load = 1'b1;
      step();
      div_load = 1'b0;
      check_eq("load_halted_pend", int'(upd_pend), 0);
      for (int i = 0; i < 16; i++) begin
         wait_tick(20, g);
         check_eq($sformatf("div6_gap%0d", i), g, 6);
         check_eq($sformatf("div6_br%0d", i), int'(br), (i == 15) ? 1 : 0);
      end

      // div=6 frac=8: gaps 6,7,6,7...; 32 gaps total 208
      restart(6, 8);
      wait_tick(20, g);
      check_eq("frac_first", g, 6);
      sum = 0;
      for (int k = 1; k <= 32; k++) begin
         wait_tick(20, g);
         if (g > 0) sum += g;
         if (k <= 4) check_eq($sformatf("frac_gap%0d", k), g, (k % 2 == 1) ? 6 : 7);
      end
      check_eq("frac_span32", sum, 208);

      // Load div=10 while cnt==3: current period stays 6
      restart(6, 0);
      wait_tick(20, g);
      check_eq("upd_first", g, 6);
      step();
      step();
      div = 16'd10; div_load = 1'b1;
      step();
      div_load = 1'b0;
      check_eq("upd_pend_a", int'(upd_pend), 1);
      check_eq("upd_notick_a", int'(tick), 0);
      step();
      check_eq("upd_pend_b", int'(upd_pend), 1);
      step();
      check_eq("upd_pend_c", int'(upd_pend), 1);
      step();
      check_eq("upd_old_period_tick", int'(tick), 1);
      check_eq("upd_pend_clr", int'(upd_pend), 0);
      wait_tick(30, g);
      check_eq("upd_new_gap", g, 10);

      // Load 0 while running: current period completes, then halted
      div = 16'd0; div_load = 1'b1;
      step();
      div_load = 1'b0;
      wait_tick(30, g);
      check_eq("zero_last_gap", g, 9);
      wait_tick(30, g);
      check_eq("zero_no_tick", g, -1);
      div = 16'd4; div_load = 1'b1;
      step();
      div_load = 1'b0;
      check_eq("resume_pend", int'(upd_pend), 0);
      wait_tick(20, g);
      check_eq("resume_first", g, 4);
      wait_tick(20, g);
      check_eq("resume_gap", g, 4);

      // div=1 frac=0: tick every cycle; OVS=1 strobe on every tick
      restart(1, 0);
      cnt_t = 0; cnt_b = 0; cnt_b1 = 0;
      for (int i = 0; i < 32; i++) begin
         step();
         cnt_t  += int'(tick);
         cnt_b  += int'(br);
         cnt_b1 += int'(br1);
      end
      check_eq("div1_ticks", cnt_t, 32);
      check_eq("div1_br16", cnt_b, 2);
      check_eq("div1_br_ovs1", cnt_b1, 32);

      // div=1 frac=8: carry stretches every other period to 2
      restart(1, 8);
      cnt_t = 0;
      for (int i = 0; i < 30; i++) begin
         step();
         cnt_t += int'(tick);
      end
      check_eq("div1_frac_ticks", cnt_t, 20);

      // Reset mid-period with a pending update
      restart(20, 0);
      for (int i = 0; i < 7; i++) step();
      div = 16'd5; div_load = 1'b1;
      step();
      div_load = 1'b0;
      check_eq("rst_pre_pend", int'(upd_pend), 1);
      rst = 1'b1;
      step();
      check_eq("midrst_tick", int'(tick), 0);
      check_eq("midrst_br", int'(br), 0);
      check_eq("midrst_pend", int'(upd_pend), 0);
      rst = 1'b0;
      wait_tick(60, g);
      check_eq("midrst_no_tick", g, -1);
      check_eq("midrst_pend_after", int'(upd_pend), 0);

      check_eq("stray_br", stray_br, 0);
      check_eq("ovs1_track", mis1, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
